// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one result bit per clock using a shift-add
// multiplier and a restoring divider. Divide-by-zero and signed overflow are resolved
// in a single cycle without iterating.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          request a new operation; accepted only while busy is low
//   funct3         RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   aluop1/aluop2  rs1 (multiplicand / dividend), rs2 (multiplier / divisor)
//   kill           abort any in-flight operation; wins over start
//   busy           high while an operation is in flight, including the done cycle
//   done           one-cycle pulse; aluout carries the new result in this cycle
//   aluout         result; holds until the next done
module mdu_iter #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned CNT_W   = $clog2(D_WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] aluop1,
  input  logic [D_WIDTH-1:0] aluop2,
  input  logic               kill,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] aluout
);

  localparam int unsigned W = D_WIDTH;
  localparam logic [D_WIDTH-1:0] MinVal = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     opa_q, opa_d;    // multiplicand magnitude
  logic [W-1:0]     opb_q, opb_d;    // multiplier (shifts right) or divisor magnitude
  logic [2*W-1:0]   acc_q, acc_d;    // product accumulator
  logic [W-1:0]     quot_q, quot_d;  // dividend shifts out MSB-first, quotient shifts in
  logic [W-1:0]     rem_q, rem_d;
  logic             neg_q, neg_d;    // product / quotient sign
  logic             rneg_q, rneg_d;  // remainder sign
  logic [W-1:0]     aluout_q, aluout_d;

  // Operand decode, only meaningful in StIdle
  logic         op1_signed, op2_signed, sign1, sign2, div_zero, div_ovf;
  logic [W-1:0] mag1, mag2;

  always_comb begin
    op1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    op2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign1      = op1_signed && aluop1[W-1];
    sign2      = op2_signed && aluop2[W-1];
    mag1       = sign1 ? -aluop1 : aluop1;
    mag2       = sign2 ? -aluop2 : aluop2;
    div_zero   = (aluop2 == '0);
    div_ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                 (aluop1 == MinVal) && (&aluop2);
  end

  // One iteration of each datapath
  logic [2*W-1:0] addend;
  logic [W:0]     trial, diff;

  always_comb begin
    addend = {{W{1'b0}}, opa_q} << cnt_q;
    trial  = {rem_q, quot_q[W-1]};
    diff   = trial - {1'b0, opb_q};
  end

  // Sign correction and result selection for the done cycle
  logic [2*W-1:0] prod;
  logic [W-1:0]   qv, rv, result;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    qv   = neg_q ? -quot_q : quot_q;
    rv   = rneg_q ? -rem_q : rem_q;
    unique case (op_q)
      3'b000:                 result = prod[W-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*W-1:W];
      3'b100, 3'b101:         result = qv;
      default:                result = rv;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    aluout_d = aluout_q;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !kill) begin
          op_d   = funct3;
          opa_d  = mag1;
          opb_d  = mag2;
          acc_d  = '0;
          cnt_d  = '0;
          neg_d  = sign1 ^ sign2;
          rneg_d = sign1;
          quot_d = mag1;
          rem_d  = '0;
          state_d = StCalc;
          if (funct3[2] && (div_zero || div_ovf)) begin
            // Final values go straight into quot/rem with sign correction disabled
            quot_d  = div_zero ? '1 : aluop1;
            rem_d   = div_zero ? aluop1 : '0;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = StDone;
          end
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          rem_d  = diff[W] ? trial[W-1:0] : diff[W-1:0];
          quot_d = {quot_q[W-2:0], ~diff[W]};
        end else begin
          if (opb_q[0]) acc_d = acc_q + addend;
          opb_d = opb_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (kill) begin
          state_d = StIdle;
        end else if (cnt_q == CNT_W'(W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!kill) begin
          done     = 1'b1;
          aluout_d = result;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The result is passed through in the done cycle and held in aluout_q afterwards
  assign aluout = done ? result : aluout_q;
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      aluout_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      aluout_q <= aluout_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (D_WIDTH = 32): a vector table of operations with
// expected result and latency, a scoreboard queue checked on every done pulse, and
// hand-written sequences for kill, reset, and start-while-busy.
module tb_mdu_iter;

  logic        clk, rst, start, kill, busy, done;
  logic [2:0]  funct3;
  logic [31:0] aluop1, aluop2, aluout;

  mdu_iter #(.D_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .aluop1 (aluop1),
    .aluop2 (aluop2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .aluout (aluout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } sb_t;

  sb_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] last_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      sb_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with aluout 0x%08h, expected no done", aluout);
      end else begin
        e = sb.pop_front();
        chk(e.name, aluout, e.val);
      end
    end
  end

  task automatic do_op(input vec_t v);
    int lat, busy_cyc;
    bit seen;
    @(negedge clk);
    funct3 = v.f3;
    aluop1 = v.a;
    aluop2 = v.b;
    start  = 1'b1;
    sb.push_back('{name: v.name, val: v.exp});
    @(posedge clk);
    #1;
    start  = 1'b0;
    // Operands are free to change once accepted
    funct3 = 3'($urandom);
    aluop1 = $urandom;
    aluop2 = $urandom;
    lat = 1;
    busy_cyc = 0;
    seen = 1'b0;
    while (1) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (lat >= 40) break;
      @(posedge clk);
      lat++;
    end
    chk({v.name, "_done_seen"}, 32'(seen), 32'd1);
    chk({v.name, "_latency"}, lat, v.lat);
    chk({v.name, "_busy_cycles"}, busy_cyc, v.lat);
    @(negedge clk);
    chk({v.name, "_busy_after"}, 32'(busy), 32'd0);
    last_exp = v.exp;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"mul_7_m3",       3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
      '{"mul_big",        3'b000, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 33},
      '{"mul_min_min",    3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33},
      '{"mulh_min_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
      '{"mulh_m1_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33},
      '{"mulhu_max",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{"mulhu_2p31_2",   3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33},
      '{"mulhsu_m1_max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
      '{"div_m7_2",       3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
      '{"rem_m7_2",       3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
      '{"div_100_m7",     3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33},
      '{"rem_100_m7",     3'b110, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 33},
      '{"rem_m100_7",     3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 33},
      '{"div_min_2",      3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33},
      '{"divu_fffe_2",    3'b101, 32'hFFFF_FFFE, 32'h0000_0002, 32'h7FFF_FFFF, 33},
      '{"remu_13_4",      3'b111, 32'd13,        32'd4,         32'h0000_0001, 33},
      '{"divu_min_m1",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33},
      '{"remu_min_m1",    3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33},
      '{"div_5_0",        3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{"rem_5_0",        3'b110, 32'd5,         32'd0,         32'h0000_0005, 1},
      '{"divu_5_0",       3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{"remu_1234_0",    3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1},
      '{"div_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{"rem_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
    };

    rst    = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = '0;
    aluop1 = '0;
    aluop2 = '0;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_aluout", aluout, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_aluout", aluout, 32'd0);

    foreach (vecs[i]) do_op(vecs[i]);

    // Kill ten cycles into a DIV: no done, idle next cycle, aluout unchanged
    @(negedge clk);
    funct3 = 3'b100;
    aluop1 = 32'd100;
    aluop2 = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    chk("kill_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy_after", 32'(busy), 32'd0);
    chk("kill_aluout_held", aluout, last_exp);
    do_op('{"after_kill_remu", 3'b111, 32'd13, 32'd4, 32'h0000_0001, 33});

    // Kill in the same cycle as start: nothing is accepted
    @(negedge clk);
    funct3 = 3'b000;
    aluop1 = 32'd3;
    aluop2 = 32'd3;
    start  = 1'b1;
    kill   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    @(negedge clk);
    chk("kill_beats_start_busy", 32'(busy), 32'd0);

    // Reset mid-MUL clears outputs immediately
    @(negedge clk);
    funct3 = 3'b000;
    aluop1 = 32'd11;
    aluop2 = 32'd13;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_aluout", aluout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;

    // Start while busy is ignored: exactly one done, with the first result
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      funct3 = 3'b000;
      aluop1 = 32'h1234_5678;
      aluop2 = 32'h0000_0009;
      start  = 1'b1;
      sb.push_back('{name: "busy_start_first", val: 32'hA3D7_0A38});
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      funct3 = 3'b100;
      aluop1 = 32'd5;
      aluop2 = 32'd0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk("busy_start_done_count", done_cnt - d0, 32'd1);
    end

    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over a parametrised data width. It sits beside the single-cycle ALU in the execute stage and takes operands from the same `aluop1`/`aluop2` sources. It computes one result bit per clock using a shift-add multiplier and a restoring divider. A start/busy/done handshake lets the pipeline stall while an operation is in flight. A `kill` input cancels in-flight work on a flush.

## Interface
- `D_WIDTH`, 32: operand and result width; must be ≥ 4 and even.
- `CNT_W`, $clog2(D_WIDTH)+1: iteration counter width; derived, do not override.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a new operation; accepted only when `busy`=0.
- `funct3` in 3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `aluop1` in D_WIDTH: rs1 (multiplicand / dividend).
- `aluop2` in D_WIDTH: rs2 (multiplier / divisor).
- `kill` in 1: abort current operation, return to IDLE next cycle.
- `busy` out 1: high from the cycle after acceptance until `done` is low again.
- `done` out 1: one-cycle pulse; `aluout` valid in this cycle.
- `aluout` out D_WIDTH: result; holds until the next `done`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, with `start`=1 and `kill`=0:
  - Latch `funct3`.
  - Latch the magnitudes of the signed operands. Signedness per op: MULH both; MULHSU `aluop1` only; DIV/REM both. All others are unsigned.
  - Latch the result sign flags: product sign = XOR of the operand signs; quotient sign = XOR; remainder sign = dividend sign.
  - Clear the counter; go to CALC.
  - Fast path for divide ops, bypassing CALC and going straight to DONE:
    - Divisor = 0: quotient = all ones; remainder = `aluop1` unmodified.
    - Signed overflow (DIV/REM with `aluop1` = 1 followed by zeros and `aluop2` = all ones): quotient = `aluop1`; remainder = 0.
- CALC, multiply: 2·D_WIDTH-bit accumulator. Each cycle, if multiplier LSB=1, add the multiplicand shifted by the counter.
- CALC, divide: restoring division MSB-first. Each cycle: shift the remainder left by 1, subtract the divisor, keep the result if non-negative and set the quotient bit.
- CALC exits to DONE after exactly D_WIDTH iterations (counter = D_WIDTH−1 at the last one).
- DONE:
  - Apply sign correction (two's-complement negate when the flag is set).
  - Select the result: MUL → low half; MULH/MULHSU/MULHU → high half of the corrected 2·D_WIDTH product; DIV/DIVU → quotient; REM/REMU → remainder.
  - Register the result into `aluout`; assert `done`; go to IDLE.
- `kill`=1 in any state: next state IDLE, `done` stays 0, `aluout` unchanged. `kill` wins over `start` in the same cycle.
- `start` while `busy`=1 is ignored; there is no queueing.
- All arithmetic is modulo 2^(2·D_WIDTH) internally. Negating the most-negative value wraps, which gives the correct MULH result.

## Timing
- Reset values: `busy`=0, `done`=0, `aluout`=0, state IDLE, counter 0, all internal registers 0.
- Reset asserted mid-operation aborts immediately (asynchronous); no `done` is produced.
- Normal latency: `start` accepted at edge N → `done`=1 during cycle N+D_WIDTH+1 (33 cycles for D_WIDTH=32).
- Fast-path latency: `done` during cycle N+1.
- `busy` is high from cycle N+1 through the `done` cycle inclusive. `busy` = (state ≠ IDLE).
- Earliest back-to-back `start` is the cycle after `done`.
- Operands and `funct3` may change freely after the acceptance edge.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `aluout`=0xFFFFFFEB; `done` exactly 33 cycles after `start`; `busy` high 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF. REMU 13/4 → 1.
- DIV 5/0 → 0xFFFFFFFF, and REM 5/0 → 5, each with `done` 1 cycle after `start`. DIV 0x80000000/−1 → 0x80000000; REM same operands → 0.
- `kill` asserted 10 cycles into a DIV → no `done`, `busy` low next cycle, `aluout` retains its previous value. A new `start` the following cycle completes normally.
- `rst` pulsed mid-MUL → all outputs 0 immediately. A second `start` while `busy` is ignored: exactly one `done`, with the first operation's result.
